// File: rtl/mesm6_mem_arbiter.sv
// Arbitrates the MESM-6 ibus/dbus onto one single-port synchronous 48-bit RAM; dones align in HOLD.
// Define MESM6_ARB_IFETCH_FIRST_EN to service the instruction fetch before the data access.
module mesm6_mem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_BITS    = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ibus_fetch,
  input  logic [ADDR_BITS-1:0] ibus_addr,
  output logic [47:0]          ibus_input,
  output logic                 ibus_done,
  input  logic                 dbus_read,
  input  logic                 dbus_write,
  input  logic [ADDR_BITS-1:0] dbus_addr,
  input  logic [47:0]          dbus_output,
  output logic [47:0]          dbus_input,
  output logic                 dbus_done,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [47:0]          mem_wdata,
  input  logic [47:0]          mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    D_ISSUE = 3'd1,
    D_WAIT  = 3'd2,
    I_ISSUE = 3'd3,
    I_WAIT  = 3'd4,
    HOLD    = 3'd5
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_t               state, state_n;
  logic                 need_i, need_d, op_wr;
  logic [ADDR_BITS-1:0] i_addr_q, d_addr_q;
  logic [47:0]          wdata_q;
  logic                 acc_done;
  logic [2:0]           lat_cnt;

  assign ibus_done = (state == HOLD) && need_i;
  assign dbus_done = (state == HOLD) && need_d;

  always_comb begin
    state_n   = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
`ifdef MESM6_ARB_IFETCH_FIRST_EN
        if (ibus_fetch)                   state_n = I_ISSUE;
        else if (dbus_read || dbus_write) state_n = D_ISSUE;
`else
        if (dbus_read || dbus_write)      state_n = D_ISSUE;
        else if (ibus_fetch)              state_n = I_ISSUE;
`endif
      end
      D_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = op_wr;
        mem_addr  = d_addr_q;
        mem_wdata = wdata_q;
        state_n   = D_WAIT;
      end
      // Each access leaves its wait state one cycle after acc_done is registered.
      D_WAIT: begin
        if (acc_done) begin
`ifdef MESM6_ARB_IFETCH_FIRST_EN
          state_n = HOLD;
`else
          state_n = need_i ? I_ISSUE : HOLD;
`endif
        end
      end
      I_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = i_addr_q;
        state_n  = I_WAIT;
      end
      I_WAIT: begin
        if (acc_done) begin
`ifdef MESM6_ARB_IFETCH_FIRST_EN
          state_n = need_d ? D_ISSUE : HOLD;
`else
          state_n = HOLD;
`endif
        end
      end
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      need_i     <= 1'b0;
      need_d     <= 1'b0;
      op_wr      <= 1'b0;
      i_addr_q   <= '0;
      d_addr_q   <= '0;
      wdata_q    <= '0;
      acc_done   <= 1'b0;
      lat_cnt    <= '0;
      ibus_input <= '0;
      dbus_input <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          need_i   <= ibus_fetch;
          need_d   <= dbus_read | dbus_write;
          op_wr    <= dbus_write;
          i_addr_q <= ibus_addr;
          d_addr_q <= dbus_addr;
          wdata_q  <= dbus_output;
        end
        D_ISSUE: begin
          acc_done <= op_wr;
          lat_cnt  <= '0;
        end
        D_WAIT: begin
          if (acc_done) begin
            acc_done <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
            if (lat_cnt == LAT_LAST) begin
              dbus_input <= mem_rdata;
              acc_done   <= 1'b1;
            end
          end
        end
        I_ISSUE: begin
          acc_done <= 1'b0;
          lat_cnt  <= '0;
        end
        I_WAIT: begin
          if (acc_done) begin
            acc_done <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
            if (lat_cnt == LAT_LAST) begin
              ibus_input <= mem_rdata;
              acc_done   <= 1'b1;
            end
          end
        end
        HOLD: begin
          need_i <= 1'b0;
          need_d <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// Directed bench for mesm6_mem_arbiter: instance 0 at READ_LATENCY=1, instance 1 at READ_LATENCY=2.
module tb_mesm6_mem_arbiter;

  localparam logic [47:0] W123 = 48'hABCD_1234_5678;
  localparam logic [47:0] W10  = 48'h1111_2222_0010;
  localparam logic [47:0] W20  = 48'h3333_4444_0020;
`ifdef MESM6_ARB_IFETCH_FIRST_EN
  localparam logic [14:0] FIRST_ADDR  = 15'o00010;
  localparam logic [14:0] SECOND_ADDR = 15'o00020;
`else
  localparam logic [14:0] FIRST_ADDR  = 15'o00020;
  localparam logic [14:0] SECOND_ADDR = 15'o00010;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_fetch [2];
  logic        dbus_read  [2];
  logic        dbus_write [2];
  logic [14:0] ibus_addr, dbus_addr;
  logic [47:0] dbus_output;
  logic [47:0] ibus_input [2];
  logic [47:0] dbus_input [2];
  logic [47:0] mem_wdata  [2];
  logic [47:0] mem_rdata  [2];
  logic [14:0] mem_addr   [2];
  logic        ibus_done  [2];
  logic        dbus_done  [2];
  logic        mem_en     [2];
  logic        mem_we     [2];

  logic [47:0] mem  [2][0:32767];
  logic [47:0] pipe [2][4];
  logic [63:0] acc_log [2][64];
  int          en_cnt [2]    = '{0, 0};
  int          ddone_cnt [2] = '{0, 0};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        snap_i, snap_d;

  always #5 clk = ~clk;

  mesm6_mem_arbiter #(.READ_LATENCY(1), .ADDR_BITS(15)) u_dut0 (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch[0]), .ibus_addr(ibus_addr), .ibus_input(ibus_input[0]), .ibus_done(ibus_done[0]),
    .dbus_read(dbus_read[0]), .dbus_write(dbus_write[0]), .dbus_addr(dbus_addr), .dbus_output(dbus_output),
    .dbus_input(dbus_input[0]), .dbus_done(dbus_done[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
  );

  mesm6_mem_arbiter #(.READ_LATENCY(2), .ADDR_BITS(15)) u_dut1 (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch[1]), .ibus_addr(ibus_addr), .ibus_input(ibus_input[1]), .ibus_done(ibus_done[1]),
    .dbus_read(dbus_read[1]), .dbus_write(dbus_write[1]), .dbus_addr(dbus_addr), .dbus_output(dbus_output),
    .dbus_input(dbus_input[1]), .dbus_done(dbus_done[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
  );

  // RAM models: read data is valid for exactly one cycle, READ_LATENCY cycles after mem_en.
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mem[k][15'o00123] <= W123;
        mem[k][15'o00010] <= W10;
        mem[k][15'o00020] <= W20;
      end else if (mem_en[k] && mem_we[k]) begin
        mem[k][mem_addr[k]] <= mem_wdata[k];
      end
      pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? mem[k][mem_addr[k]] : 48'h0;
      for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_en[k]) begin
        acc_log[k][en_cnt[k] % 64] <= {mem_we[k], mem_addr[k], mem_wdata[k]};
        en_cnt[k] <= en_cnt[k] + 1;
      end
      if (dbus_done[k]) ddone_cnt[k] <= ddone_cnt[k] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request group on an instance and drops it in the HOLD cycle, as the core would.
  task automatic group(input int inst, input logic f, input logic rd, input logic wr,
                       input logic [14:0] ia, input logic [14:0] da, input logic [47:0] wd,
                       output int lat);
    int  req_c;
    bit  seen;
    ibus_addr   = ia;
    dbus_addr   = da;
    dbus_output = wd;
    ibus_fetch[inst] = f;
    dbus_read[inst]  = rd;
    dbus_write[inst] = wr;
    req_c = cyc;
    lat   = -1;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      if (ibus_done[inst] || dbus_done[inst]) begin
        seen   = 1'b1;
        lat    = cyc - req_c;
        snap_i = ibus_done[inst];
        snap_d = dbus_done[inst];
      end
    end
    ibus_fetch[inst] = 1'b0;
    dbus_read[inst]  = 1'b0;
    dbus_write[inst] = 1'b0;
    chk("grp_done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    int          lat, n0, d0, nd;
    int          dc [3];
    bit          seen;
    logic [63:0] e;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ibus_fetch[k] = 1'b0;
      dbus_read[k]  = 1'b0;
      dbus_write[k] = 1'b0;
    end
    ibus_addr     = 15'o00123;
    dbus_addr     = '0;
    dbus_output   = '0;
    ibus_fetch[0] = 1'b1;
    snap_i        = 1'b0;
    snap_d        = 1'b0;

    // Reset held with a fetch pending
    step();
    step();
    chk("rst_ctrl", 64'({ibus_done[0], dbus_done[0], mem_en[0], mem_we[0]}), 64'd0);
    chk("rst_addr", 64'(mem_addr[0]), 64'd0);
    chk("rst_data", 64'(ibus_input[0] | dbus_input[0] | mem_wdata[0]), 64'd0);
    chk("rst_no_en", 64'(en_cnt[0]), 64'd0);
    step();
    reset = 1'b0;
    chk("rst_idle_no_en", 64'(mem_en[0]), 64'd0);
    step();
    chk("rst_first_en", 64'(mem_en[0]), 64'd1);
    chk("rst_first_addr", 64'(mem_addr[0]), 64'(15'o00123));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (ibus_done[0]) seen = 1'b1;
    end
    ibus_fetch[0] = 1'b0;
    chk("rst_fetch_done", 64'(seen), 64'd1);
    step();

    // Fetch only, latency 1
    n0 = en_cnt[0];
    group(0, 1'b1, 1'b0, 1'b0, 15'o00123, 15'o0, 48'h0, lat);
    e = acc_log[0][n0 % 64];
    chk("fetch_lat", 64'(lat), 64'd4);
    chk("fetch_idone", 64'(snap_i), 64'd1);
    chk("fetch_ddone", 64'(snap_d), 64'd0);
    chk("fetch_data", 64'(ibus_input[0]), 64'(W123));
    chk("fetch_en_count", 64'(en_cnt[0] - n0), 64'd1);
    chk("fetch_we", 64'(e[63]), 64'd0);
    chk("fetch_addr", 64'(e[62:48]), 64'(15'o00123));
    step();
    chk("fetch_done_one_cycle", 64'(ibus_done[0]), 64'd0);

    // Write to the top word, then read it back
    n0 = en_cnt[0];
    group(0, 1'b0, 1'b0, 1'b1, 15'o0, 15'o77777, 48'h0000_0000_0042, lat);
    e = acc_log[0][n0 % 64];
    chk("wr_lat", 64'(lat), 64'd3);
    chk("wr_dones", 64'({snap_i, snap_d}), 64'd1);
    chk("wr_en_count", 64'(en_cnt[0] - n0), 64'd1);
    chk("wr_we", 64'(e[63]), 64'd1);
    chk("wr_addr", 64'(e[62:48]), 64'(15'o77777));
    chk("wr_wdata", 64'(e[47:0]), 64'h42);
    step();
    chk("wr_done_one_cycle", 64'(dbus_done[0]), 64'd0);
    group(0, 1'b0, 1'b1, 1'b0, 15'o0, 15'o77777, 48'h0, lat);
    chk("rdback_lat", 64'(lat), 64'd4);
    chk("rdback_data", 64'(dbus_input[0]), 64'h42);
    step();

    // Simultaneous fetch and read, latency 2
    n0 = en_cnt[1];
    group(1, 1'b1, 1'b1, 1'b0, 15'o00010, 15'o00020, 48'h0, lat);
    chk("both_lat", 64'(lat), 64'd9);
    chk("both_dones_aligned", 64'({snap_i, snap_d}), 64'd3);
    chk("both_en_count", 64'(en_cnt[1] - n0), 64'd2);
    e = acc_log[1][n0 % 64];
    chk("both_first_addr", 64'(e[62:48]), 64'(FIRST_ADDR));
    e = acc_log[1][(n0 + 1) % 64];
    chk("both_second_addr", 64'(e[62:48]), 64'(SECOND_ADDR));
    chk("both_idata", 64'(ibus_input[1]), 64'(W10));
    chk("both_ddata", 64'(dbus_input[1]), 64'(W20));
    step();
    chk("both_done_one_cycle", 64'({ibus_done[1], dbus_done[1]}), 64'd0);

    // Read and write together: a single write, read data untouched
    n0 = en_cnt[0];
    d0 = ddone_cnt[0];
    group(0, 1'b0, 1'b1, 1'b1, 15'o0, 15'o00100, 48'h5A5A, lat);
    step();
    step();
    e = acc_log[0][n0 % 64];
    chk("rw_lat", 64'(lat), 64'd3);
    chk("rw_en_count", 64'(en_cnt[0] - n0), 64'd1);
    chk("rw_is_write", 64'(e[63]), 64'd1);
    chk("rw_wdata", 64'(e[47:0]), 64'h5A5A);
    chk("rw_done_pulses", 64'(ddone_cnt[0] - d0), 64'd1);
    chk("rw_rdata_kept", 64'(dbus_input[0]), 64'h42);

    // Read held across three groups
    n0 = en_cnt[0];
    nd = 0;
    dbus_addr    = 15'o00020;
    dbus_read[0] = 1'b1;
    for (int i = 0; i < 60 && nd < 3; i++) begin
      step();
      if (dbus_done[0]) begin
        dc[nd] = cyc;
        nd++;
      end
    end
    dbus_read[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("b2b_done_pulses", 64'(nd), 64'd3);
    chk("b2b_en_count", 64'(en_cnt[0] - n0), 64'd3);
    if (nd == 3) begin
      chk("b2b_gap1", 64'(dc[1] - dc[0]), 64'd5);
      chk("b2b_gap2", 64'(dc[2] - dc[1]), 64'd5);
    end
    chk("b2b_data", 64'(dbus_input[0]), 64'(W20));

    // Reset during D_WAIT on the latency-2 instance
    n0 = en_cnt[1];
    d0 = ddone_cnt[1];
    dbus_addr    = 15'o00020;
    dbus_read[1] = 1'b1;
    step();
    chk("rstw_issue_en", 64'(mem_en[1]), 64'd1);
    step();
    reset        = 1'b1;
    dbus_read[1] = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("rstw_no_done", 64'(ddone_cnt[1] - d0), 64'd0);
    chk("rstw_en_count", 64'(en_cnt[1] - n0), 64'd1);
    chk("rstw_dinput_cleared", 64'(dbus_input[1]), 64'd0);
    chk("rstw_idle_en", 64'(mem_en[1]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesm6_mem_arbiter.md
Name: mesm6_mem_arbiter

Overview:
- Sits directly below the MESM-6 core.
- Merges the core's instruction bus (ibus) and data bus (dbus) onto one single-port synchronous 48-bit RAM.
- Serialises simultaneous requests and returns per-port done handshakes that match the core's stall rule: the core stalls while any active request lacks done.
- Holds done and read data stable until the core's microinstruction advances.

Parameters:
- READ_LATENCY, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..4.
- ADDR_BITS, 15, word address width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- ibus_fetch  in  1  instruction fetch request, level, held until done
- ibus_addr  in  15  instruction word address
- ibus_input  out  48  fetched instruction word
- ibus_done  out  1  fetch complete
- dbus_read  in  1  data read request, level
- dbus_write  in  1  data write request, level
- dbus_addr  in  15  data word address
- dbus_output  in  48  write data from core
- dbus_input  out  48  read data to core
- dbus_done  out  1  data operation complete
- mem_en  out  1  RAM access strobe, one cycle per access
- mem_we  out  1  RAM write enable, qualified by mem_en
- mem_addr  out  15  RAM address
- mem_wdata  out  48  RAM write data
- mem_rdata  in  48  RAM read data

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; group flags cleared. Reset mid-access abandons the access, and any pending done is lost.
- Group capture: in IDLE, sample needI = ibus_fetch and needD = dbus_read|dbus_write. If either is set, latch a group:
  - needI, needD
  - op = write if dbus_write, else read (both high means write; the read is dropped)
  - both addresses
  - dbus_output
- Service order: data first, then instruction.
- States:
  - IDLE: capture the group. D_ISSUE if needD, else I_ISSUE if needI, else stay.
  - D_ISSUE: mem_en=1, mem_addr=latched dbus_addr, mem_we=(op==write), mem_wdata=latched data.
    - Write: mark D done this cycle end and go to next.
    - Read: start the latency counter and go to D_WAIT.
  - D_WAIT: count to READ_LATENCY. In the cycle mem_rdata is valid, capture it into dbus_input and mark D done. Go to I_ISSUE if needI, else HOLD.
  - I_ISSUE / I_WAIT: same as the data read path, using ibus_addr. Capture into ibus_input and mark I done. Go to HOLD.
  - HOLD: dbus_done=needD, ibus_done=needI, both asserted together. Go to IDLE next cycle; clear both dones and group flags on that transition.
- Done timing:
  - A port's done goes high only in HOLD.
  - All requested dones are high in the same single cycle, so the core's busy drops exactly once per group.
  - Unrequested done stays 0.
  - Read data outputs keep their last captured value until overwritten by a later read. They are not cleared by a group end.
- Latency from request visible in IDLE to done high:
  - write only: 3 cycles
  - data read: 3+READ_LATENCY cycles
  - fetch only: 3+READ_LATENCY cycles
  - both reads: 5+2*READ_LATENCY cycles
- Back-to-back: a request still asserted in the IDLE cycle after HOLD starts a new group. The core has loaded a new microinstruction by then, so this is a new operation and no access is duplicated.
- Requests that change or drop while a group is in flight are ignored until the next IDLE.
- Exactly one mem_en pulse per serviced access; no RAM access in IDLE or HOLD.
- Address arithmetic: none, addresses pass through unmodified.

Optional Feature:
- Macro: MESM6_ARB_IFETCH_FIRST_EN.
- Defined: within a group, the instruction fetch is serviced before the data access (IDLE goes to I_ISSUE when needI; after I done, go to D_ISSUE if needD). Done alignment in HOLD is unchanged.
- Undefined: data first, as above.

Test Plan:
- Reset asserted with ibus_fetch=1: all outputs 0 during reset; no mem_en until one cycle after reset drops.
- Fetch only, READ_LATENCY=1, ibus_addr=0o00123, RAM word 0xABCD_1234_5678:
  - single mem_en with mem_we=0 and mem_addr=0o00123
  - ibus_input=0xABCD_1234_5678 with ibus_done=1 for exactly one cycle, 4 cycles after request
  - dbus_done stays 0
- Write, dbus_addr=0o77777, dbus_output=0x0000_0000_0042: one mem_en with mem_we=1 and mem_wdata=0x42; dbus_done pulse 3 cycles after request; a following read of 0o77777 returns 0x42.
- Simultaneous fetch of 0o00010 and read of 0o00020, READ_LATENCY=2:
  - mem_addr sequence 0o00020 then 0o00010
  - ibus_done and dbus_done high in the same single cycle, 9 cycles after request
  - MESM6_ARB_IFETCH_FIRST_EN build: order 0o00010 then 0o00020
- dbus_read=dbus_write=1: exactly one access, a write; dbus_done pulses once.
- Request held continuously for 3 groups: exactly 3 mem_en pulses, 3 done pulses, with one IDLE cycle between groups. Reset asserted during D_WAIT returns to IDLE with no done.
